alu_src_sequencer: RTL and testbench
====================================

// Module: alu_src_sequencer
// PURPOSE
//  Multicycle control FSM that sequences the shared ALU of the datapath. Each cycle it
//  drives the ALU operand-A select (PC / A reg / zero), operand-B select, ALU op, and
//  the PC/IR/regfile write strobes for one instruction per start request.
//  Sits between instruction-issue logic (start/busy/done) and the datapath muxes.
// PARAMETERS
//  OPW     6   opcode and funct field width
// PORTS
//  clk          in   1   single clock; all state changes on rising edge
//  rst_n        in   1   synchronous reset, active low
//  start        in   1   request one instruction; sampled only in IDLE
//  stall        in   1   instruction memory not ready; holds FETCH
//  opcode       in   6   IR[31:26]; valid from DECODE onward
//  funct        in   6   IR[5:0]; valid from DECODE onward
//  zero         in   1   ALU zero flag, combinational from current ALU result
//  alu_src_a    out  2   00 PC, 01 A reg, 10 constant 0 (11 never driven)
//  alu_src_b    out  2   00 B reg, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op       out  3   000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
//  pc_write     out  1   load PC from ALU result this cycle
//  ir_write     out  1   load IR from memory this cycle
//  reg_write    out  1   write ALUOut to rd (R-type) or rt (I-type)
//  reg_dst_rd   out  1   1: destination rd, 0: rt (meaningful only with reg_write)
//  busy         out  1   high in every state except IDLE
//  done         out  1   one-cycle pulse in the final state of an instruction
//  illegal      out  1   one-cycle pulse, coincident with done, on unknown encoding
// BEHAVIOUR
//  - Moore FSM; outputs decoded from state register (+opcode/zero where noted).
//  - rst_n low at an edge -> state IDLE next cycle. While rst_n is low, all strobes
//    (pc_write, ir_write, reg_write, done, illegal) are forced 0 combinationally.
//  - IDLE outputs / reset values: alu_src_a=00, alu_src_b=00, alu_op=000, all strobes 0, busy 0.
//  - IDLE: start=1 -> FETCH, else stay.
//  - FETCH: src_a=00, src_b=01, ADD. stall=1: stay, ir_write=0, pc_write=0.
//    stall=0: ir_write=1, pc_write=1 (PC+4), -> DECODE.
//  - DECODE: src_a=00, src_b=11, ADD (branch target into ALUOut). Next state by opcode:
//    0x00 with funct in {0x20,0x22,0x24,0x25,0x26} -> EX_R; 0x08/0x0C/0x0D -> EX_I;
//    0x0F (li) -> EX_LI; 0x04 (beq)/0x05 (bne) -> BRANCH; anything else -> IDLE with
//    done=1, illegal=1 (no write strobes).
//  - EX_R: src_a=01, src_b=00; op: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR -> WB.
//  - EX_I: src_a=01, src_b=10; op: 0x08 ADD, 0x0C AND, 0x0D OR -> WB.
//  - EX_LI: src_a=10 (zero), src_b=10, ADD -> WB.
//  - WB: reg_write=1, reg_dst_rd=1 iff opcode==0x00; done=1 -> IDLE.
//  - BRANCH: src_a=01, src_b=00, SUB; pc_write = zero (beq) or !zero (bne); done=1 -> IDLE.
//  - Latency from start-accept edge (stall=0): ALU/li = 4 cycles to done, branch = 3;
//    each stall cycle adds one. start while busy is ignored (no queueing).
//  - start in the same cycle as done: ignored; FSM is in IDLE the next cycle and accepts
//    start then.
//  - Reset in any state (incl. FETCH with stall, WB) aborts; no partial strobe issued.
// TESTING
//  1 reset: rst_n=0 2 cycles -> IDLE, busy=0, all strobes 0, src_a=00; start ignored.
//  2 add: start, opcode=0x00 funct=0x20, stall=0 -> ir_write+pc_write cycle 1,
//    EX_R src_a=01 src_b=00 op=000 cycle 3, reg_write+reg_dst_rd+done cycle 4.
//  3 li with stall=1 for 3 cycles: FETCH held 4 cycles, no ir_write until stall drops;
//    EX_LI src_a=10 src_b=10 op=000; done 7 cycles after start-accept.
//  4 beq zero=1 -> pc_write=1 with done cycle 3; bne zero=1 -> pc_write=0, done=1.
//  5 opcode=0x3F -> DECODE then done=1 illegal=1, no reg_write/pc_write; next start works.
//  6 rst_n=0 in EX_R -> next cycle IDLE, reg_write never asserted; start held during busy
//    -> exactly one instruction executed.

Source files
------------

// File: rtl/alu_src_sequencer.sv
// alu_src_sequencer
//   Multicycle control FSM for the shared ALU. Accepts one instruction per start
//   request and, cycle by cycle, drives the ALU operand selects, the ALU op and
//   the PC / IR / register-file write strobes.
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             instruction request (sampled only in IDLE)
//   stall             instruction memory not ready (holds FETCH)
//   opcode, funct     IR fields, valid from DECODE onward
//   zero              ALU zero flag (combinational)
//   alu_src_a/_b      operand selects; alu_op ALU operation
//   pc_write, ir_write, reg_write, reg_dst_rd   datapath strobes
//   busy, done, illegal                        issue handshake / status
module alu_src_sequencer #(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           stall,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  output logic [1:0]     alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [2:0]     alu_op,
  output logic           pc_write,
  output logic           ir_write,
  output logic           reg_write,
  output logic           reg_dst_rd,
  output logic           busy,
  output logic           done,
  output logic           illegal
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'h00);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'h04);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'h05);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'h08);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'h0C);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'h0D);
  localparam logic [OPW-1:0] OP_LI    = OPW'(6'h0F);
  localparam logic [OPW-1:0] FN_ADD   = OPW'(6'h20);
  localparam logic [OPW-1:0] FN_SUB   = OPW'(6'h22);
  localparam logic [OPW-1:0] FN_AND   = OPW'(6'h24);
  localparam logic [OPW-1:0] FN_OR    = OPW'(6'h25);
  localparam logic [OPW-1:0] FN_XOR   = OPW'(6'h26);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_EX_LI, S_WB, S_BRANCH
  } state_t;

  state_t state_q, state_d;

  logic is_r, is_i, is_li, is_br;

  // Instruction class decode, used by DECODE to pick the execute state
  always_comb begin
    is_r  = (opcode == OP_RTYPE) &&
            (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
             funct == FN_OR  || funct == FN_XOR);
    is_i  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    is_li = (opcode == OP_LI);
    is_br = (opcode == OP_BEQ) || (opcode == OP_BNE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (!stall) state_d = S_DECODE;
      S_DECODE: begin
        if (is_r)       state_d = S_EX_R;
        else if (is_i)  state_d = S_EX_I;
        else if (is_li) state_d = S_EX_LI;
        else if (is_br) state_d = S_BRANCH;
        else            state_d = S_IDLE;
      end
      S_EX_R, S_EX_I, S_EX_LI: state_d = S_WB;
      S_WB, S_BRANCH:          state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst_rd = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = !stall;
        pc_write  = !stall;
      end
      S_DECODE: begin
        // Branch target is computed speculatively here into ALUOut
        alu_src_b = 2'b11;
        if (!(is_r || is_i || is_li || is_br)) begin
          done    = 1'b1;
          illegal = 1'b1;
        end
      end
      S_EX_R: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b00;
        unique case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_EX_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        unique case (opcode)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_EX_LI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst_rd = (opcode == OP_RTYPE);
        done       = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = ALU_SUB;
        pc_write  = (opcode == OP_BEQ) ? zero : !zero;
        done      = 1'b1;
      end
      default: ;
    endcase
    // Reset masks every strobe immediately so an aborted instruction issues nothing
    if (!rst_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      done      = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_src_sequencer.sv
module tb_alu_src_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, stall, zero;
  logic [5:0] opcode, funct;
  logic [1:0] alu_src_a, alu_src_b;
  logic [2:0] alu_op;
  logic       pc_write, ir_write, reg_write, reg_dst_rd, busy, done, illegal;

  int checks = 0;
  int failures = 0;

  alu_src_sequencer #(.OPW(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .opcode(opcode), .funct(funct), .zero(zero),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst_rd(reg_dst_rd), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {src_a, src_b, op, pc_write, ir_write, reg_write, reg_dst_rd, busy, done, illegal}
  logic [13:0] obs;
  assign obs = {alu_src_a, alu_src_b, alu_op, pc_write, ir_write, reg_write,
                reg_dst_rd, busy, done, illegal};
  localparam logic [13:0] STROBES = 14'h0073;

  logic [13:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] ev(input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] op, input logic pcw,
                                     input logic irw, input logic rw, input logic rd,
                                     input logic dn, input logic il);
    return {a, b, op, pcw, irw, rw, rd, 1'b1, dn, il};
  endfunction

  // ALU op for an R-type funct; 7 marks an unsupported funct
  function automatic logic [2:0] r_op(input logic [5:0] fn);
    case (fn)
      6'h20: return 3'd0;
      6'h22: return 3'd1;
      6'h24: return 3'd2;
      6'h25: return 3'd3;
      6'h26: return 3'd4;
      default: return 3'd7;
    endcase
  endfunction

  // Expected per-cycle outputs of one instruction, from the cycle after start is accepted
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int nstall);
    logic legal;
    exp_q.delete();
    for (int k = 0; k < nstall; k++) exp_q.push_back(ev(2'd0, 2'd1, 3'd0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(2'd0, 2'd1, 3'd0, 1, 1, 0, 0, 0, 0));
    legal = (op == 6'h00 && r_op(fn) != 3'd7) || op == 6'h08 || op == 6'h0C ||
            op == 6'h0D || op == 6'h0F || op == 6'h04 || op == 6'h05;
    exp_q.push_back(ev(2'd0, 2'd3, 3'd0, 0, 0, 0, 0, !legal, !legal));
    if (!legal) return;
    if (op == 6'h04 || op == 6'h05) begin
      exp_q.push_back(ev(2'd1, 2'd0, 3'd1, (op == 6'h04) ? z : !z, 0, 0, 0, 1, 0));
      return;
    end
    if (op == 6'h00)      exp_q.push_back(ev(2'd1, 2'd0, r_op(fn), 0, 0, 0, 0, 0, 0));
    else if (op == 6'h08) exp_q.push_back(ev(2'd1, 2'd2, 3'd0, 0, 0, 0, 0, 0, 0));
    else if (op == 6'h0C) exp_q.push_back(ev(2'd1, 2'd2, 3'd2, 0, 0, 0, 0, 0, 0));
    else if (op == 6'h0D) exp_q.push_back(ev(2'd1, 2'd2, 3'd3, 0, 0, 0, 0, 0, 0));
    else                  exp_q.push_back(ev(2'd2, 2'd2, 3'd0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(2'd0, 2'd0, 3'd0, 0, 0, 1, op == 6'h00, 1, 0));
  endtask

  // abort_at: -1 none, -2 random cycle, else cycle index at which rst_n is pulled low.
  // lat returns the DUT-observed cycles from start-accept to done (0 if none/aborted).
  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int nstall, input logic hold_start,
                     input int abort_at, output int lat);
    int ab;
    lat = 0;
    build(op, fn, z, nstall);
    ab = (abort_at == -2) ? int'($urandom_range(0, exp_q.size() - 1)) : abort_at;
    start = 1'b1; opcode = op; funct = fn; zero = z; stall = 1'b0;
    #2 chk({name, "_idle"}, obs, 14'h0);
    @(posedge clk); #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      start = hold_start;
      stall = (i < nstall) ? 1'b1 : (i == nstall) ? 1'b0 : 1'($urandom);
      if (i == ab) begin
        rst_n = 1'b0;
        #2 chk({name, "_abort_strobes"}, obs & STROBES, 14'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        #2 chk({name, "_post_reset"}, obs, 14'h0);
        @(posedge clk); #1;
        return;
      end
      #2 chk($sformatf("%s_c%0d", name, i + 1), obs, exp_q[i]);
      if (done && lat == 0) lat = i + 1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [5:0] op, fn;
    logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
    logic [5:0] iops[3] = '{6'h08, 6'h0C, 6'h0D};

    // Reset with start asserted
    rst_n = 1'b0; start = 1'b1; stall = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h20;
    #2 chk("rst_strobes", obs & STROBES, 14'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    #1 chk("rst_idle", obs, 14'h0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_start_ignored", obs, 14'h0);

    run("add", 6'h00, 6'h20, 1'b0, 0, 1'b1, -1, lat);
    chk("add_latency", lat, 4);
    run("li", 6'h0F, 6'h11, 1'b0, 3, 1'b0, -1, lat);
    chk("li_latency", lat, 7);
    run("beq_z1", 6'h04, 6'h00, 1'b1, 0, 1'b0, -1, lat);
    chk("beq_latency", lat, 3);
    run("bne_z1", 6'h05, 6'h00, 1'b1, 0, 1'b0, -1, lat);
    chk("bne_latency", lat, 3);
    run("illegal", 6'h3F, 6'h00, 1'b0, 0, 1'b0, -1, lat);
    chk("illegal_latency", lat, 2);
    run("after_illegal", 6'h00, 6'h26, 1'b0, 1, 1'b0, -1, lat);
    chk("after_illegal_latency", lat, 5);
    run("abort_exr", 6'h00, 6'h22, 1'b0, 0, 1'b1, 2, lat);
    run("abort_fetch", 6'h08, 6'h00, 1'b0, 3, 1'b0, 1, lat);
    run("abort_wb", 6'h0D, 6'h00, 1'b0, 0, 1'b0, 3, lat);
    run("sub_held", 6'h00, 6'h22, 1'b0, 2, 1'b1, -1, lat);
    chk("sub_latency", lat, 6);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin op = 6'h00; fn = fns[$urandom_range(0, 4)]; end
        3:       begin op = 6'h00; fn = 6'($urandom); end
        4, 5:    begin op = iops[$urandom_range(0, 2)]; fn = 6'($urandom); end
        6:       begin op = 6'h0F; fn = 6'($urandom); end
        7, 8:    begin op = ($urandom_range(0, 1) == 1) ? 6'h04 : 6'h05; fn = 6'($urandom); end
        default: begin op = 6'($urandom); fn = 6'($urandom); end
      endcase
      run($sformatf("rnd%0d", n), op, fn, 1'($urandom), $urandom_range(0, 3),
          1'($urandom), ($urandom_range(0, 9) == 0) ? -2 : -1, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
